// File: rtl/mioc_od_pkg.sv
// Shared definitions for the open-drain single-wire link: receiver state
// encoding and the default timing used by both line ends.
package mioc_od_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } od_state_e;

  localparam int unsigned FILT_LEN = 3;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned BIT1_MAX = 60;
  localparam int unsigned RST_MIN  = 400;
  localparam int unsigned IDLE_TO  = 1000;

endpackage

// File: rtl/mioc_od_filt.sv
// Two-flop synchronizer and glitch filter for the raw open-drain line.
// Produces the filtered level plus one-cycle fall/rise strobes aligned with it.
module mioc_od_filt
  import mioc_od_pkg::*;
#(
  parameter int unsigned FILT_LEN = mioc_od_pkg::FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic od_in,
  output logic lvl,
  output logic fall,
  output logic rise
);

  localparam int unsigned FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            lvl_q, lvl_d;
  logic            fall_q, fall_d;
  logic            rise_q, rise_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  // The level flips on the FILT_LEN-th consecutive differing sample;
  // any sample equal to the current level restarts the count.
  always_comb begin
    sync1_d = od_in;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    fcnt_d  = '0;
    if (sync2_q != lvl_q) begin
      if (fcnt_q == FC_LAST) begin
        lvl_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = lvl_q & ~lvl_d;
    rise_d = ~lvl_q & lvl_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      fcnt_q  <= fcnt_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  assign lvl  = lvl_q;
  assign fall = fall_q;
  assign rise = rise_q;

endmodule

// File: rtl/mioc_od_rx.sv
// Open-drain single-wire receiver: measures filtered low pulses, decodes
// data 1 / data 0 / bus reset, and assembles bytes LSB first.
module mioc_od_rx
  import mioc_od_pkg::*;
#(
  parameter int unsigned FILT_LEN = mioc_od_pkg::FILT_LEN,
  parameter int unsigned CNT_W    = mioc_od_pkg::CNT_W,
  parameter int unsigned BIT1_MAX = mioc_od_pkg::BIT1_MAX,
  parameter int unsigned RST_MIN  = mioc_od_pkg::RST_MIN,
  parameter int unsigned IDLE_TO  = mioc_od_pkg::IDLE_TO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       od_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       bit_valid,
  output logic       bit_val,
  output logic       bus_rst,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] B1_LIM  = CNT_W'(BIT1_MAX);
  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(RST_MIN);
  localparam logic [CNT_W-1:0] ITO_LIM = CNT_W'(IDLE_TO);

  logic line_lvl, line_fall, line_rise;

  mioc_od_filt #(
    .FILT_LEN(FILT_LEN)
  ) u_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .od_in(od_in),
    .lvl  (line_lvl),
    .fall (line_fall),
    .rise (line_rise)
  );

  od_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_val_q, bit_val_d;
  logic             bus_rst_q, bus_rst_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bcnt_d       = bcnt_q;
    sh_d         = sh_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    bit_valid_d  = 1'b0;
    bit_val_d    = 1'b0;
    bus_rst_d    = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (line_fall) begin
          cnt_d   = CNT_ONE;
          state_d = LOW;
        end
      end

      LOW: begin
        cnt_d = cnt_inc;
        if (line_rise) begin
          cnt_d = '0;
          if (cnt_q >= RST_LIM) begin
            bus_rst_d = 1'b1;
            bcnt_d    = '0;
            sh_d      = '0;
            state_d   = IDLE;
          end else begin
            bit_valid_d = 1'b1;
            bit_val_d   = (cnt_q < B1_LIM);
            sh_d        = {bit_val_d, sh_q[7:1]};
            state_d     = HIGH;
            if (bcnt_q == 3'd7) begin
              data_out_d   = sh_d;
              data_valid_d = 1'b1;
              bcnt_d       = '0;
              sh_d         = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end

      HIGH: begin
        cnt_d = cnt_inc;
        // A new pulse wins over a timeout landing in the same cycle.
        if (line_fall) begin
          cnt_d   = CNT_ONE;
          state_d = LOW;
        end else if (cnt_inc == ITO_LIM) begin
          frame_err_d = (bcnt_q != 3'd0);
          bcnt_d      = '0;
          sh_d        = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      sh_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_val_q    <= 1'b0;
      bus_rst_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      sh_q         <= sh_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      bit_valid_q  <= bit_valid_d;
      bit_val_q    <= bit_val_d;
      bus_rst_q    <= bus_rst_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign bit_valid  = bit_valid_q;
  assign bit_val    = bit_val_q;
  assign bus_rst    = bus_rst_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == LOW) || (bcnt_q != 3'd0);

endmodule

// File: tb/tb_mioc_od_rx.sv
// Bench for mioc_od_rx: drives timed low pulses and compares observed
// strobes against a pulse-level reference model plus a boundary table.
module tb_mioc_od_rx;

  localparam int FILT = 3;
  localparam int B1   = 60;
  localparam int RMIN = 400;
  localparam int ITO  = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       od_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, bit_valid, bit_val, bus_rst, frame_err, busy;

  always #5 clk = ~clk;

  mioc_od_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .od_in     (od_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .bus_rst   (bus_rst),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef enum int {K_BIT, K_BYTE, K_RST, K_FERR, K_BAD} kind_e;
  typedef struct {
    kind_e  kind;
    int     val;
    longint cyc;
  } ev_t;
  typedef struct {
    int    low_w;
    kind_e kind;
    int    val;
  } vec_t;

  ev_t    obs_q[$];
  ev_t    exp_q[$];
  int     m_bitq[$];
  int     m_last_byte = 0;
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;

  // Strobe monitor: data_valid must coincide with bit_valid, other strobes exclusive.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if ($countones({bit_valid, bus_rst, frame_err}) > 1 || (data_valid && !bit_valid)) begin
        obs_q.push_back('{K_BAD, int'({bit_valid, data_valid, bus_rst, frame_err}), cyc});
      end else begin
        if (bit_valid)  obs_q.push_back('{K_BIT, int'(bit_val), cyc});
        if (data_valid) obs_q.push_back('{K_BYTE, int'(data_out), cyc});
        if (bus_rst)    obs_q.push_back('{K_RST, 0, cyc});
        if (frame_err)  obs_q.push_back('{K_FERR, 0, cyc});
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_ev(input string name, input kind_e kind, input int val);
    ev_t o;
    tests++;
    if (obs_q.size() == 0) begin
      fails++;
      $display("FAIL %s: got no event, required %s val=0x%0h", name, kind.name(), val);
    end else begin
      o = obs_q.pop_front();
      if (o.kind != kind || o.val != val) begin
        fails++;
        $display("FAIL %s: got %s val=0x%0h, required %s val=0x%0h",
                 name, o.kind.name(), o.val, kind.name(), val);
      end
    end
  endtask

  task automatic check_events(input string name);
    ev_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_ev(name, e.kind, e.val);
    end
    chk({name, " extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  // Reference model: works on whole pulse widths and gap lengths.
  function automatic void mdl_low(input int w);
    int b;
    int v;
    if (w >= RMIN) begin
      exp_q.push_back('{K_RST, 0, 0});
      m_bitq.delete();
      return;
    end
    b = (w < B1) ? 1 : 0;
    exp_q.push_back('{K_BIT, b, 0});
    m_bitq.push_back(b);
    if (m_bitq.size() == 8) begin
      v = 0;
      foreach (m_bitq[i]) v += m_bitq[i] * (1 << i);
      exp_q.push_back('{K_BYTE, v, 0});
      m_last_byte = v;
      m_bitq.delete();
    end
  endfunction

  function automatic void mdl_high(input int h);
    if (h > ITO && m_bitq.size() != 0) begin
      exp_q.push_back('{K_FERR, 0, 0});
      m_bitq.delete();
    end
  endfunction

  // Entered and left at posedge+1: od_in holds v across exactly n sampling edges.
  task automatic drive(input logic v, input int n);
    od_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int w, input int h);
    drive(1'b0, w);
    mdl_low(w);
    drive(1'b1, h);
    mdl_high(h);
  endtask

  task automatic send_byte(input string name, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      pulse(b[i] ? 20 : 120, 80);
      check_events(name);
    end
  endtask

  vec_t        tbl[6];
  int          w, h, cat;
  logic [7:0]  rb;

  initial begin
    tbl[0] = '{20,  K_BIT, 1};
    tbl[1] = '{120, K_BIT, 0};
    tbl[2] = '{59,  K_BIT, 1};
    tbl[3] = '{60,  K_BIT, 0};
    tbl[4] = '{399, K_BIT, 0};
    tbl[5] = '{400, K_RST, 0};

    // Reset with the line toggling
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      od_in = ~od_in;
      @(negedge clk);
      chk("reset_outputs", int'({data_out, data_valid, bit_valid, bit_val, bus_rst, frame_err, busy}), 0);
      @(posedge clk); #1;
    end
    od_in = 1'b1;
    obs_q.delete();
    rst_n = 1'b1;
    drive(1'b1, 20);
    check_events("idle_after_reset");

    // Single byte 0xA5
    pulse(20, 80);
    check_events("a5_bit0");
    chk("busy_mid_byte", int'(busy), 1);
    for (int i = 1; i < 8; i++) begin
      pulse(((8'hA5 >> i) & 1) != 0 ? 20 : 120, 80);
      check_events("a5_bits");
    end
    chk("a5_data_out", int'(data_out), 8'hA5);
    chk("busy_after_byte", int'(busy), 0);

    // Glitch rejection inside a high gap, then a 3-cycle low is a real bit
    pulse(20, 80);
    drive(1'b0, 1); drive(1'b1, 20);
    drive(1'b0, 2); drive(1'b1, 20);
    check_events("glitch_reject");
    pulse(FILT, 80);
    check_events("glitch_min_pulse");

    // Bus reset after 3 bits, then a fresh byte
    pulse(120, 80);
    check_events("pre_rst_bit3");
    pulse(500, 80);
    check_events("bus_rst_mid_byte");
    chk("busy_after_bus_rst", int'(busy), 0);
    send_byte("fresh_byte", 8'h3C);
    chk("fresh_data_out", int'(data_out), 8'h3C);

    // Pulse-width boundaries from the table
    foreach (tbl[i]) begin
      drive(1'b0, tbl[i].low_w);
      drive(1'b1, 80);
      mdl_low(tbl[i].low_w);
      exp_q.delete();
      chk_ev($sformatf("width_%0d", tbl[i].low_w), tbl[i].kind, tbl[i].val);
      chk("width_single_event", obs_q.size(), 0);
      obs_q.delete();
    end

    // Idle timeout after 5 bits
    for (int i = 0; i < 4; i++) begin
      pulse(20, 80);
      check_events("ito_bits");
    end
    drive(1'b0, 120);
    mdl_low(120);
    drive(1'b1, ITO + 100);
    mdl_high(ITO + 100);
    if (obs_q.size() == 2) chk("ito_delay", int'(obs_q[1].cyc - obs_q[0].cyc), ITO);
    else chk("ito_event_count", obs_q.size(), 2);
    check_events("idle_timeout");
    chk("busy_after_timeout", int'(busy), 0);
    chk("data_out_held", int'(data_out), m_last_byte);

    // Reset mid-byte discards the partial byte silently
    for (int i = 0; i < 3; i++) begin
      pulse(120, 80);
      check_events("pre_reset_bits");
    end
    rst_n = 1'b0;
    drive(1'b1, 2);
    rst_n = 1'b1;
    m_bitq.delete();
    drive(1'b1, 20);
    check_events("reset_mid_byte");
    chk("busy_after_reset", int'(busy), 0);
    send_byte("post_reset_byte", 8'h96);
    chk("post_reset_data_out", int'(data_out), 8'h96);

    // Stuck low far past counter saturation
    drive(1'b0, 2500);
    chk("busy_stuck_low", int'(busy), 1);
    drive(1'b0, 2500);
    mdl_low(5000);
    drive(1'b1, 80);
    check_events("stuck_low");

    // Randomized pulse trains against the model
    for (int n = 0; n < 40; n++) begin
      cat = $urandom_range(0, 9);
      if (cat < 4)      w = $urandom_range(FILT, B1 - 1);
      else if (cat < 8) w = $urandom_range(B1, RMIN - 1);
      else              w = $urandom_range(RMIN, 700);
      h = ($urandom_range(0, 6) == 0) ? ITO + 100 : $urandom_range(10, 200);
      pulse(w, h);
      check_events($sformatf("rand_%0d_w%0d_h%0d", n, w, h));
    end
    rb = 8'($urandom_range(0, 255));
    send_byte("rand_byte", rb);
    chk("rand_byte_data_out", int'(data_out), int'(rb));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mioc_od_rx.md
Name: mioc_od_rx

Overview:
- Receiver end of the open-drain single-wire line. A remote open-drain driver pulls the line low, and an external pullup returns it high.
- Samples the line, synchronizes and glitch-filters it, then measures each low pulse.
- Classifies each low pulse as data 1, data 0 or bus reset, and assembles bits LSB-first into bytes.
- Sits between the pad-level open-drain line and the byte-wide control logic.

Parameters:
FILT_LEN, 3, consecutive equal synchronized samples required to change filtered level (>=1)
CNT_W, 12, width of pulse/idle counter
BIT1_MAX, 60, low pulse shorter than this many cycles = data 1
RST_MIN, 400, low pulse of at least this many cycles = bus reset
IDLE_TO, 1000, high time in cycles that aborts a partial byte

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
od_in  input  1  raw open-drain line, asynchronous, idle high
data_out  output  8  last completed byte, LSB received first
data_valid  output  1  one-cycle strobe, data_out updated
bit_valid  output  1  one-cycle strobe per decoded data bit
bit_val  output  1  value of decoded bit, qualified by bit_valid
bus_rst  output  1  one-cycle strobe, reset pulse detected
frame_err  output  1  one-cycle strobe, partial byte discarded on idle timeout
busy  output  1  high while a byte is partially received or a low pulse is in progress

Behaviour:
- Reset (rst_n low at clk edge), all synchronous:
  - Sync flops = 1; filtered level = 1; filter count = 0.
  - State = IDLE; counter = 0; bit count = 0; shift reg = 0.
  - data_out = 0x00; all strobes = 0; busy = 0.
- Reset mid-byte discards the partial byte with no strobe.
- Synchronizer: two flops on od_in.
- Filter: the filtered level changes only after FILT_LEN consecutive synchronized samples differ from the current filtered level. Any matching sample clears the filter count.
- Fall = filtered 1->0; rise = filtered 0->1.
- Input-to-filtered latency: 2 + FILT_LEN cycles.
- Counter saturates at 2^CNT_W-1 and never wraps.
- States:
  - IDLE (line high, bit count 0, counter held 0):
    - On fall: counter = 1, go LOW.
  - LOW (measuring): counter increments each cycle.
    - On rise with width W = counter:
      - W < BIT1_MAX: bit 1.
      - BIT1_MAX <= W < RST_MIN: bit 0.
      - W >= RST_MIN: bus_rst pulse; bit count = 0; shift reg = 0; go IDLE.
    - On a data bit:
      - bit_valid = 1 and bit_val = bit, both in the cycle after the rise.
      - Shift reg shifts right with the bit into [7].
      - Bit count increments.
      - Counter = 0; go HIGH.
  - HIGH (between bits): counter increments.
    - On fall: counter = 1; go LOW.
    - When counter reaches IDLE_TO with bit count in 1..7: frame_err pulse; clear bit count and shift reg; go IDLE.
    - If bit count = 0: go IDLE when counter reaches IDLE_TO, with no error.
- Byte complete: when the 8th bit is decoded, in the same cycle as bit_valid:
  - data_out = final shifted value; data_valid = 1; bit count = 0.
  - State goes HIGH. IDLE_TO expiry with bit count 0 then returns to IDLE silently.
- A reset pulse during a partial byte produces bus_rst only, not frame_err.
- Strobes are mutually exclusive, except that bit_valid and data_valid coincide on the 8th bit.
- busy = (state == LOW) or (bit count != 0).
- A line stuck low: the counter saturates and the state stays LOW with no strobe until the rise. The rise then classifies the pulse as bus reset.
- data_out holds its value until the next completed byte.

Decomposition:
- Package mioc_od_pkg holds:
  - State enum: IDLE, LOW, HIGH.
  - Default timing constants: BIT1_MAX, RST_MIN, IDLE_TO, FILT_LEN.
  - Shared with the future open-drain transmitter so both ends use identical timing.
- One sub-module: mioc_od_filt. It contains the 2-flop synchronizer plus the FILT_LEN glitch filter and outputs the filtered level and fall/rise strobes.

Test Plan:
1. Reset: hold rst_n low 5 cycles with od_in toggling -> every output 0, busy 0. After release, od_in high for 20 cycles -> no strobes.
2. Single byte 0xA5: send LSB first, bit 1 = 20-cycle low, bit 0 = 120-cycle low, 80-cycle high gaps.
   - bit_valid 8 times with bit_val 1,0,1,0,0,1,0,1.
   - data_valid exactly once, coincident with the 8th bit_valid, data_out = 0xA5.
3. Glitch rejection: during a high gap, apply 1- and 2-cycle low glitches on od_in (FILT_LEN=3) -> no fall detected, no strobes. A 3-cycle low is accepted as a fall.
4. Bus reset: 500-cycle low mid-byte, after 3 bits -> bus_rst one pulse, no frame_err, no bit_valid. Next 8 bits form a fresh byte.
5. Idle timeout: send 5 bits, then hold high 1000+ cycles -> frame_err one pulse exactly IDLE_TO cycles after the 5th bit's rise, busy drops to 0, data_out unchanged.
6. Boundaries: low width exactly 59 -> bit 1; 60 -> bit 0; 399 -> bit 0; 400 -> bus_rst. Stuck low for 5000 cycles, then release -> counter saturated, single bus_rst.
